// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank with a double-buffered BCD frame.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

    logic [PW-1:0]                 presc_reg, presc_next;
    logic [IW-1:0]                 idx_reg, idx_next;
    logic [BW-1:0]                 blank_reg, blank_next;
    logic [NUM_DIGITS-1:0][3:0]    active_bcd_reg;
    logic [NUM_DIGITS-1:0]         active_dp_reg;
    logic [NUM_DIGITS-1:0][3:0]    pending_bcd_reg;
    logic [NUM_DIGITS-1:0]         pending_dp_reg;
    logic                          pending_valid_reg;
    logic [7:0]                    seg_reg, seg_next;
    logic [NUM_DIGITS-1:0]         an_reg, an_next;
    logic [NUM_DIGITS-1:0]         an_dec;
    logic                          load_ack_reg;
    logic                          frame_start_reg;
    logic                          tick;
    logic                          wrap;
    logic                          transfer;
    logic [3:0]                    cur_nibble;
    logic                          cur_dp;
    logic [7:0]                    glyph;

    assign tick     = (presc_reg == PRESC_LAST);
    assign wrap     = tick && (idx_reg == IDX_LAST);
    assign transfer = wrap && pending_valid_reg;

    always_comb begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        idx_next   = idx_reg;
        blank_next = blank_reg;
        if (tick) begin
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            blank_next = BLANK_LOAD;
        end else if (blank_reg != '0) begin
            blank_next = blank_reg - 1'b1;
        end
    end

    // One-hot-low anode pattern for the current digit, replaced by all-off during the blank window.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
            assign an_dec[gi] = (idx_reg != IW'(gi));
        end
    endgenerate

    assign an_next = (blank_reg != '0) ? '1 : an_dec;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask_reg;
    logic [NUM_DIGITS-1:0] lz_mask_next;
    logic [NUM_DIGITS:0]   lz_chain;

    localparam logic [NUM_DIGITS-1:0] LZ_RESET = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

    // Suppression runs down from the top digit and stops at the first non-zero nibble or lit dp.
    assign lz_chain[NUM_DIGITS] = 1'b1;
    assign lz_chain[0]          = 1'b0;
    assign lz_mask_next[0]      = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            assign lz_chain[gi]     = lz_chain[gi+1] && (pending_bcd_reg[gi] == 4'h0) && !pending_dp_reg[gi];
            assign lz_mask_next[gi] = lz_chain[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            lz_mask_reg <= LZ_RESET;
        end else if (transfer) begin
            lz_mask_reg <= lz_mask_next;
        end
    end
`endif

    assign cur_nibble = active_bcd_reg[idx_reg];
    assign cur_dp     = active_dp_reg[idx_reg];

    always_comb begin
        case (cur_nibble)
            4'h0:    glyph = 8'hC0;
            4'h1:    glyph = 8'hF9;
            4'h2:    glyph = 8'hA4;
            4'h3:    glyph = 8'hB0;
            4'h4:    glyph = 8'h99;
            4'h5:    glyph = 8'h92;
            4'h6:    glyph = 8'h82;
            4'h7:    glyph = 8'hF8;
            4'h8:    glyph = 8'h80;
            4'h9:    glyph = 8'h90;
            4'hA:    glyph = 8'h7F;
            default: glyph = 8'hFF;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (lz_mask_reg[idx_reg]) begin
            glyph = 8'hFF;
        end
`endif
        seg_next = {glyph[7] & ~cur_dp, glyph[6:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg         <= '0;
            idx_reg           <= '0;
            blank_reg         <= BLANK_LOAD;
            active_bcd_reg    <= '0;
            active_dp_reg     <= '0;
            pending_bcd_reg   <= '0;
            pending_dp_reg    <= '0;
            pending_valid_reg <= 1'b0;
            seg_reg           <= 8'hFF;
            an_reg            <= '1;
            load_ack_reg      <= 1'b0;
            frame_start_reg   <= 1'b0;
        end else begin
            presc_reg       <= presc_next;
            idx_reg         <= idx_next;
            blank_reg       <= blank_next;
            seg_reg         <= seg_next;
            an_reg          <= an_next;
            frame_start_reg <= wrap;
            load_ack_reg    <= transfer;
            if (transfer) begin
                active_bcd_reg <= pending_bcd_reg;
                active_dp_reg  <= pending_dp_reg;
            end
            // A load coinciding with the transfer keeps the new data pending for the next frame.
            if (load) begin
                pending_bcd_reg   <= bcd_in;
                pending_dp_reg    <= dp_in;
                pending_valid_reg <= 1'b1;
            end else if (wrap) begin
                pending_valid_reg <= 1'b0;
            end
        end
    end

    assign seg_out     = seg_reg;
    assign an_out      = an_reg;
    assign load_ack    = load_ack_reg;
    assign frame_start = frame_start_reg;

endmodule
